requant_scheduler: RTL

//  Shares one int32->int8 requantization pipeline among NUM_REQ accumulator lanes of the conv/FC engine.
//  Per request: fixed-point multiply (saturating rounding doubling high mul, SRDHM), then rounding

---
 rtl/quant_pkg.sv | 48 ++++
 rtl/rdbpot_round.sv | 27 ++
 rtl/requant_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared requantization definitions.
//   - Q31 rounding constants and int32/int8 limits
//   - requant_cfg_t: one per-channel table entry {mult, shift}
//   - srdhm(): saturating rounding doubling high multiply of two int32 values
package quant_pkg;

    localparam logic [31:0]        Q31_NUDGE_POS = 32'h4000_0000;
    localparam logic signed [31:0] INT32_MIN     = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX     = 32'sh7FFF_FFFF;
    localparam logic signed [7:0]  INT8_MIN      = 8'sh80;
    localparam logic signed [7:0]  INT8_MAX      = 8'sh7F;

    // Nudges in 65-bit form so the sum with a 64-bit product cannot overflow.
    localparam logic signed [64:0] SRDHM_NUDGE_POS = $signed({33'd0, Q31_NUDGE_POS});
    localparam logic signed [64:0] SRDHM_NUDGE_NEG = -65'sd1073741823;
    // Bias that turns an arithmetic (floor) shift into truncation toward zero.
    localparam logic signed [64:0] SRDHM_TRUNC_BIAS = 65'sd2147483647;

    typedef struct packed {
        logic signed [31:0] mult;
        logic [4:0]         shift;
    } requant_cfg_t;

    // r = (a*b + nudge) / 2^31, truncated toward zero. The only product that
    // does not fit the result is INT32_MIN*INT32_MIN, which saturates.
    function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] a_ext;
        logic signed [63:0] b_ext;
        logic signed [63:0] prod;
        logic signed [64:0] sum;
        logic signed [31:0] res;
        a_ext = a;
        b_ext = b;
        prod  = a_ext * b_ext;
        sum   = $signed({prod[63], prod}) + (prod[63] ? SRDHM_NUDGE_NEG : SRDHM_NUDGE_POS);
        if (sum[64]) begin
            sum = sum + SRDHM_TRUNC_BIAS;
        end
        if (a == INT32_MIN && b == INT32_MIN) begin
            res = INT32_MAX;
        end else begin
            res = $signed(sum[62:31]);
        end
        return res;
    endfunction

endpackage

// File: rtl/rdbpot_round.sv
// Rounding divide by power of two (round half away from zero).
// Ports:
//   r     in  signed 32  value to divide
//   shift in  5          divisor exponent 0..31 (0 passes r through)
//   q     out signed 32  rounded quotient
// Purely combinational; also used on shift-only paths outside the scheduler.
module rdbpot_round (
    input  logic signed [31:0] r,
    input  logic [4:0]         shift,
    output logic signed [31:0] q
);

    logic [31:0] mask;
    logic [31:0] rem;
    logic [31:0] thr;
    logic        round_up;

    always_comb begin
        mask     = (32'd1 << shift) - 32'd1;
        rem      = r & mask;
        // Negative values need one more unit of remainder to round away from zero.
        thr      = (mask >> 1) + {31'd0, r[31]};
        round_up = (rem > thr);
        q        = (r >>> shift) + $signed({31'd0, round_up});
    end

endmodule

// File: rtl/requant_scheduler.sv
// Shared int32 -> int8 requantization pipeline for NUM_REQ accumulator lanes.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/req_ready        per-lane handshake, req_ready is a one-hot grant
//   req_acc, req_ch            per-lane int32 accumulator and output channel
//   cfg_we/cfg_ch/cfg_mult/cfg_shift   per-channel table write port
//   out_offset, act_min, act_max       quasi-static output offset and clamp bounds
//   out_valid/out_ready/out_data/out_id  result stream with originating lane
//   busy                       some pipeline stage holds an item
// Stages: S0 accept (table read here), S1 SRDHM, S2 RDBPOT + offset + clamp
// which is also the output register. A stalled output freezes every stage.
module requant_scheduler
    import quant_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CH  = 64,
    parameter int CH_W    = 6,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_acc,
    input  logic [CH_W*NUM_REQ-1:0]  req_ch,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic signed [31:0]       cfg_mult,
    input  logic [4:0]               cfg_shift,
    input  logic signed [31:0]       out_offset,
    input  logic signed [7:0]        act_min,
    input  logic signed [7:0]        act_max,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [7:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     busy
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    // Per-channel table; contents deliberately survive reset.
    requant_cfg_t tbl_reg [NUM_CH];

    logic signed [31:0] lane_acc [NUM_REQ];
    logic [CH_W-1:0]    lane_ch  [NUM_REQ];

    logic               stall;
    logic               can_accept;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic               transfer;
    logic signed [31:0] sel_acc;
    requant_cfg_t       sel_cfg;

    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;

    logic               s0_valid_reg;
    logic signed [31:0] s0_acc_reg;
    logic signed [31:0] s0_mult_reg;
    logic [4:0]         s0_shift_reg;
    logic [ID_W-1:0]    s0_id_reg;

    logic               s1_valid_reg;
    logic signed [31:0] s1_r_reg;
    logic [4:0]         s1_shift_reg;
    logic [ID_W-1:0]    s1_id_reg;

    logic               s2_valid_reg;
    logic signed [7:0]  out_data_reg;
    logic [ID_W-1:0]    out_id_reg;

    logic signed [31:0] s2_q;
    logic signed [32:0] sum33;
    logic signed [32:0] min33;
    logic signed [32:0] max33;
    logic signed [7:0]  out_data_next;

    assign stall      = s2_valid_reg & ~out_ready;
    assign can_accept = ~stall & ~reset;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_acc[gi]  = req_acc[32*gi +: 32];
            assign lane_ch[gi]   = req_ch[CH_W*gi +: CH_W];
            assign req_ready[gi] = can_accept & grant_found & (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search: first requesting lane at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign sel_acc  = lane_acc[grant_idx];
    // Asynchronous read: a same-cycle table write is not yet visible here.
    assign sel_cfg  = tbl_reg[lane_ch[grant_idx]];

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (transfer) begin
            rr_ptr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_reg[cfg_ch] <= '{mult: cfg_mult, shift: cfg_shift};
        end
    end

    rdbpot_round u_round (
        .r     (s1_r_reg),
        .shift (s1_shift_reg),
        .q     (s2_q)
    );

    // Offset add is done one bit wider so a large offset saturates instead of wrapping.
    always_comb begin
        sum33 = $signed({s2_q[31], s2_q}) + $signed({out_offset[31], out_offset});
        min33 = $signed({{25{act_min[7]}}, act_min});
        max33 = $signed({{25{act_max[7]}}, act_max});
        if (act_min > act_max) begin
            out_data_next = act_max;
        end else if (sum33 < min33) begin
            out_data_next = act_min;
        end else if (sum33 > max33) begin
            out_data_next = act_max;
        end else begin
            out_data_next = $signed(sum33[7:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= '0;
            s0_valid_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
            out_id_reg   <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (!stall) begin
                s0_valid_reg <= transfer;
                s1_valid_reg <= s0_valid_reg;
                s2_valid_reg <= s1_valid_reg;
                if (transfer) begin
                    s0_acc_reg   <= sel_acc;
                    s0_mult_reg  <= sel_cfg.mult;
                    s0_shift_reg <= sel_cfg.shift;
                    s0_id_reg    <= grant_idx;
                end
                if (s0_valid_reg) begin
                    s1_r_reg     <= srdhm(s0_acc_reg, s0_mult_reg);
                    s1_shift_reg <= s0_shift_reg;
                    s1_id_reg    <= s0_id_reg;
                end
                if (s1_valid_reg) begin
                    out_data_reg <= out_data_next;
                    out_id_reg   <= s1_id_reg;
                end
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;
    assign busy      = s0_valid_reg | s1_valid_reg | s2_valid_reg;

endmodule
